// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
// Owns the program counter, drives the instruction address bus, and captures
// each fetched word together with its PC for the decode stage. Supports stall,
// flush, branch/jump redirect and a HALT word that freezes fetch until the
// next redirect or reset.
// Optional build macro FETCH_STAGE_PERF_COUNTER_EN adds o_fetch_count, a
// 32-bit count of cycles in which an instruction was advanced into IF/ID.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int                     PC_STEP     = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  output logic [PC_WIDTH-1:0]    o_pc,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_redirect,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  output logic                   o_id_valid,
  output logic [INSTR_WIDTH-1:0] o_id_instruction,
  output logic [PC_WIDTH-1:0]    o_id_pc,
`ifdef FETCH_STAGE_PERF_COUNTER_EN
  output logic [31:0]            o_fetch_count,
`endif
  output logic                   o_halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(PC_STEP);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   idValid_q, idValid_d;
  logic [INSTR_WIDTH-1:0] idInstr_q, idInstr_d;
  logic [PC_WIDTH-1:0]    idPc_q, idPc_d;
`ifdef FETCH_STAGE_PERF_COUNTER_EN
  logic [31:0]            fetchCount_q, fetchCount_d;
`endif

  // Next-state selection: redirect beats flush beats stall, then HALTED bubbles, else advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idValid_d = idValid_q;
    idInstr_d = idInstr_q;
    idPc_d    = idPc_q;
`ifdef FETCH_STAGE_PERF_COUNTER_EN
    fetchCount_d = fetchCount_q;
`endif
    if (i_redirect) begin
      pc_d      = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
      idValid_d = 1'b0;
      idInstr_d = NOP_INSTR;
      state_d   = RUN;
    end else if (i_flush) begin
      idValid_d = 1'b0;
      idInstr_d = NOP_INSTR;
    end else if (i_stall) begin
      state_d = state_q;
    end else if (state_q == HALTED) begin
      idValid_d = 1'b0;
      idInstr_d = NOP_INSTR;
    end else begin
      idValid_d = 1'b1;
      idInstr_d = i_instruction;
      idPc_d    = pc_q;
`ifdef FETCH_STAGE_PERF_COUNTER_EN
      fetchCount_d = fetchCount_q + 32'd1;
`endif
      if (i_instruction == HALT_INSTR) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_q + PcStep;
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      idValid_q <= 1'b0;
      idInstr_q <= NOP_INSTR;
      idPc_q    <= '0;
`ifdef FETCH_STAGE_PERF_COUNTER_EN
      fetchCount_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idValid_q <= idValid_d;
      idInstr_q <= idInstr_d;
      idPc_q    <= idPc_d;
`ifdef FETCH_STAGE_PERF_COUNTER_EN
      fetchCount_q <= fetchCount_d;
`endif
    end
  end

  assign o_pc             = pc_q;
  assign o_id_valid       = idValid_q;
  assign o_id_instruction = idInstr_q;
  assign o_id_pc          = idPc_q;
  assign o_halted         = (state_q == HALTED);
`ifdef FETCH_STAGE_PERF_COUNTER_EN
  assign o_fetch_count    = fetchCount_q;
`endif

endmodule
